mult_unit: RTL and testbench

//   Multi-cycle iterative multiplier for MULT/MULTU with architectural HI/LO registers.

---
 rtl/mult_unit.sv | 90 +++++++++
 tb/tb_mult_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for MULT/MULTU with architectural HI/LO.
// mult_done is low for WIDTH+1 cycles per multiply; MTHI/MTLO write HI/LO directly in IDLE.
module mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_e,
  input  logic             signed_e,
  input  logic [WIDTH-1:0] srca_e,
  input  logic [WIDTH-1:0] srcb_e,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_count;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_res;

  // Magnitude of a two's-complement value; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // Carry-out lands in bit WIDTH of the sum and becomes the new acc MSB after the shift.
  assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_res = r_neg ? -r_acc : r_acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_e) begin
            r_mcand  <= magnitude(srca_e, signed_e);
            r_mplier <= magnitude(srcb_e, signed_e);
            r_neg    <= signed_e & (srca_e[WIDTH-1] ^ srcb_e[WIDTH-1]);
            r_acc    <= '0;
            r_count  <= '0;
            r_state  <= S_CALC;
          end else begin
            if (hi_we) r_hi <= wd;
            if (lo_we) r_lo <= wd;
          end
        end
        S_CALC: begin
          r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + CW'(1);
          if (r_count == CW'(WIDTH-1)) r_state <= S_FIXUP;
        end
        S_FIXUP: begin
          r_hi    <= w_res[2*WIDTH-1:WIDTH];
          r_lo    <= w_res[WIDTH-1:0];
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign mult_done = (r_state == S_IDLE);

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: stimulus pushes expected {hi,lo}; a monitor pops on each
// completion and also checks the busy window length.
module tb_mult_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_e = 1'b0;
  logic         signed_e = 1'b0;
  logic [W-1:0] srca_e = '0;
  logic [W-1:0] srcb_e = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wd = '0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         mult_done;

  int n_vec = 0;
  int n_fail = 0;
  logic [2*W-1:0] exp_q[$];

  mult_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_e(start_e), .signed_e(signed_e),
    .srca_e(srca_e), .srcb_e(srcb_e), .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .hi(hi), .lo(lo), .mult_done(mult_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Called just after a falling edge; holds start_e across exactly one rising edge.
  task automatic start_mult(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    start_e  = 1'b1;
    signed_e = s;
    srca_e   = a;
    srcb_e   = b;
    @(negedge clk);
    start_e  = 1'b0;
    signed_e = ~s;
    srca_e   = $urandom;
    srcb_e   = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!mult_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!mult_done) begin
      n_vec++;
      n_fail++;
      $display("FAIL timeout: mult_done still %b after %0d cycles, expected 1", mult_done, n);
    end
    @(negedge clk);
  endtask

  initial begin
    fork
      begin : monitor
        logic prev_done = 1'b1;
        logic rst_q = 1'b1;
        int   low_cnt = 0;
        logic [2*W-1:0] e;
        forever begin
          @(posedge clk);
          rst_q = reset;
          @(negedge clk);
          if (mult_done && !prev_done && !rst_q) begin
            if (exp_q.size() == 0) begin
              n_vec++;
              n_fail++;
              $display("FAIL unexpected_done: got completion, expected none queued");
            end else begin
              e = exp_q.pop_front();
              chk("result", {hi, lo}, e);
              chk("busy_cycles", 64'(low_cnt), 64'(W + 1));
            end
          end
          low_cnt   = mult_done ? 0 : low_cnt + 1;
          prev_done = mult_done;
        end
      end
    join_none

    // Reset state and quiet hold
    repeat (2) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_done", 64'(mult_done), 64'h1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_stable", {hi, lo}, 64'h0);
    chk("idle_done", 64'(mult_done), 64'h1);

    // Unsigned and signed products
    exp_q.push_back(64'hFFFFFFFE_00000001);
    start_mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("busy_after_start", 64'(mult_done), 64'h0);
    wait_done();
    exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
    start_mult(1'b1, 32'hFFFFFFFD, 32'd7);
    wait_done();
    exp_q.push_back(64'h40000000_00000000);
    start_mult(1'b1, 32'h80000000, 32'h80000000);
    wait_done();

    // Restart attempt mid-operation is ignored
    exp_q.push_back(64'hFFFFFFFF_FFFFFFE8);
    start_mult(1'b1, 32'd6, 32'hFFFFFFFC);
    repeat (3) @(negedge clk);
    start_e = 1'b1; signed_e = 1'b0; srca_e = 32'd100; srcb_e = 32'd100;
    @(negedge clk);
    start_e = 1'b0;
    wait_done();

    // MTHI / MTLO
    hi_we = 1'b1; wd = 32'h12345678;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi", 64'(hi), 64'h12345678);
    lo_we = 1'b1; wd = 32'h9ABCDEF0;
    @(negedge clk);
    lo_we = 1'b0;
    chk("mtlo", 64'(lo), 64'h9ABCDEF0);
    chk("mtlo_hi_kept", 64'(hi), 64'h12345678);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'h0BADF00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mthi_mtlo_both", {hi, lo}, 64'h0BADF00D_0BADF00D);

    // Start wins over a same-cycle write; writes during CALC are dropped
    exp_q.push_back(64'h00000000_00000006);
    hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCAFEBABE;
    start_mult(1'b0, 32'd2, 32'd3);
    hi_we = 1'b0; lo_we = 1'b0;
    chk("start_beats_write", {hi, lo}, 64'h0BADF00D_0BADF00D);
    repeat (3) @(negedge clk);
    hi_we = 1'b1; wd = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 1'b0;
    chk("mthi_in_calc", {hi, lo}, 64'h0BADF00D_0BADF00D);
    wait_done();

    // Reset mid-operation discards the partial result
    start_mult(1'b0, 32'd5, 32'd5);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_done", 64'(mult_done), 64'h1);
    chk("midreset_hilo", {hi, lo}, 64'h0);
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back(64'h00000000_00000019);
    start_mult(1'b0, 32'd5, 32'd5);
    wait_done();

    chk("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
